// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the GCD job sequencer.
package gcd_pkg;

    localparam int GCD_W           = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and synchronous flush.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A push while full is still legal when the same cycle frees a slot.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front end for the GCD core: buffers operand pairs, issues one job at a time,
// short-circuits zero operands and aborts hung jobs with a watchdog.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [GCD_W-1:0] in_a,
    input  logic [GCD_W-1:0] in_b,
    output logic             gcd_go,
    output logic [GCD_W-1:0] gcd_in1,
    output logic [GCD_W-1:0] gcd_in2,
    output logic             gcd_rst,
    input  logic             gcd_done,
    input  logic [GCD_W-1:0] gcd_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [GCD_W-1:0] res_gcd,
    output logic [GCD_W-1:0] res_a,
    output logic [GCD_W-1:0] res_b,
    output logic             res_err
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    // Expiry is detected one count early so the registered gcd_rst lands
    // TIMEOUT cycles after the go pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    state_t               state;
    logic [WD_W-1:0]      watchdog;
    logic [GCD_W-1:0]     op_a;
    logic [GCD_W-1:0]     op_b;
    logic [2*GCD_W-1:0]   head;
    logic [GCD_W-1:0]     head_a;
    logic [GCD_W-1:0]     head_b;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !fifo_empty;
    assign head_a   = head[2*GCD_W-1:GCD_W];
    assign head_b   = head[GCD_W-1:0];
    assign res_a    = op_a;
    assign res_b    = op_b;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2*GCD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            watchdog  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gcd_in1   <= '0;
            gcd_in2   <= '0;
            gcd_go    <= 1'b0;
            gcd_rst   <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_gcd   <= '0;
        end else begin
            gcd_go  <= 1'b0;
            gcd_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_a <= head_a;
                        op_b <= head_b;
                        if (head_a != '0 && head_b != '0) begin
                            gcd_in1 <= head_a;
                            gcd_in2 <= head_b;
                            gcd_go  <= 1'b1;
                            state   <= S_ISSUE;
                        end else begin
                            // The core never terminates on a zero operand.
                            res_gcd   <= (head_a == '0) ? head_b : head_a;
                            res_err   <= (head_a == '0) && (head_b == '0);
                            res_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_ISSUE: begin
                    watchdog <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        state <= S_CAPTURE;
                    end else if (watchdog == WD_LAST) begin
                        gcd_rst   <= 1'b1;
                        res_gcd   <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_gcd   <= gcd_out;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural Euclid core model.
module tb_gcd_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        gcd_go, gcd_rst, gcd_done;
    logic [31:0] gcd_in1, gcd_in2, gcd_out;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_gcd, res_a, res_b;

    logic        hang, stray, core_done, busy;
    logic [31:0] x, y;
    int          cyc = 0, go_count = 0, go_cyc = 0, rst_cyc = 0, rst_cnt = 0;
    int          n_checks = 0, n_fail = 0;
    int          g0, r0;

    always #5 clk = ~clk;

    gcd_job_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .gcd_go(gcd_go), .gcd_in1(gcd_in1),
        .gcd_in2(gcd_in2), .gcd_rst(gcd_rst), .gcd_done(gcd_done),
        .gcd_out(gcd_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_gcd(res_gcd), .res_a(res_a), .res_b(res_b), .res_err(res_err)
    );

    // Euclid core: one modulo step per cycle; hang suppresses completion.
    always @(posedge clk) begin
        if (rst || gcd_rst) begin
            busy      <= 1'b0;
            core_done <= 1'b0;
            gcd_out   <= '0;
        end else begin
            core_done <= 1'b0;
            if (gcd_go) begin
                x    <= gcd_in1;
                y    <= gcd_in2;
                busy <= 1'b1;
            end else if (busy && !hang) begin
                if (y == 0) begin
                    gcd_out   <= x;
                    core_done <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    x <= y;
                    y <= x % y;
                end
            end
        end
    end
    assign gcd_done = core_done | stray;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gcd_go) begin
            go_count <= go_count + 1;
            go_cyc   <= cyc;
        end
        if (gcd_rst) begin
            rst_cnt <= rst_cnt + 1;
            rst_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit acc = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 200; k++) begin
            if (in_ready) begin
                acc = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] eg,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic ee);
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (res_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_gcd"}, res_gcd, eg);
            chk({tag, "_a"}, res_a, ea);
            chk({tag, "_b"}, res_b, eb);
            chk({tag, "_err"}, 32'(res_err), 32'(ee));
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        res_ready = 1'b0; hang = 1'b0; stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_go", 32'(gcd_go), 32'd0);
        chk("rst_gcd_rst", 32'(gcd_rst), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_res_gcd", res_gcd, 32'd0);
        chk("rst_res_a", res_a, 32'd0);
        chk("rst_in1", gcd_in1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic job through the core
        res_ready = 1'b1;
        g0 = go_count;
        push(48, 18);
        wait_result("t1", 6, 48, 18, 0);
        chk("t1_go_pulses", 32'(go_count - g0), 32'd1);

        // Single-zero and double-zero operands bypass the core
        g0 = go_count;
        push(0, 9);
        wait_result("t2a", 9, 0, 9, 0);
        push(12, 0);
        wait_result("t2b", 12, 12, 0, 0);
        push(0, 0);
        wait_result("t3", 0, 0, 0, 1);
        chk("t23_go_pulses", 32'(go_count - g0), 32'd0);

        // Stray done while idle
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_res_valid", 32'(res_valid), 32'd0);
        chk("stray_go", 32'(go_count - g0), 32'd0);

        // Back-pressure: fill the FIFO behind a stalled result
        res_ready = 1'b0;
        g0 = go_count;
        push(7, 7);
        push(21, 14);
        push(100, 75);
        push(17, 5);
        push(64, 48);
        chk("t4_full", 32'(in_ready), 32'd0);
        repeat (20) @(negedge clk);
        chk("t4_stall_valid", 32'(res_valid), 32'd1);
        chk("t4_stall_gcd", res_gcd, 32'd7);
        chk("t4_stall_ready", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_stable_gcd", res_gcd, 32'd7);
        chk("t4_stable_a", res_a, 32'd7);
        chk("t4_stable_b", res_b, 32'd7);
        chk("t4_one_job", 32'(go_count - g0), 32'd1);
        res_ready = 1'b1;
        wait_result("t4r1", 7, 7, 7, 0);
        wait_result("t4r2", 7, 21, 14, 0);
        wait_result("t4r3", 25, 100, 75, 0);
        wait_result("t4r4", 1, 17, 5, 0);
        wait_result("t4r5", 16, 64, 48, 0);

        // Watchdog abort on a hung core
        hang = 1'b1;
        r0 = rst_cnt;
        push(3, 5);
        wait_result("t5", 0, 3, 5, 1);
        repeat (2) @(negedge clk);
        chk("t5_rst_delay", 32'(rst_cyc - go_cyc), 32'd8);
        chk("t5_rst_pulses", 32'(rst_cnt - r0), 32'd1);
        hang = 1'b0;
        push(9, 6);
        wait_result("t5b", 3, 9, 6, 0);

        // Reset during WAIT drops the job and flushes the FIFO
        push(48, 18);
        push(5, 10);
        begin
            bit seen_go = 0;
            for (int k = 0; k < 20; k++) begin
                if (gcd_go) begin
                    seen_go = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("t6_go_seen", 32'(seen_go), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        g0 = go_count;
        repeat (15) @(negedge clk);
        chk("t6_no_result", 32'(res_valid), 32'd0);
        chk("t6_flushed", 32'(go_count - g0), 32'd0);
        push(48, 18);
        wait_result("t6b", 6, 48, 18, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream front end for the GCD core: accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one job at a time to the core, using a single-cycle go pulse with in1/in2 held stable, then captures the core's result.
- Presents each result downstream over valid/ready.
- Handles zero operands itself, because the core never terminates on them, and recovers a hung core with a watchdog.

Parameters:
- DEPTH, 4: input FIFO entries; power of 2, at least 2.
- TIMEOUT, 1024: cycles allowed from go pulse to gcd_done before the job is aborted.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- gcd_go  out  1  one-cycle start pulse to the core.
- gcd_in1  out  32  operand A to the core.
- gcd_in2  out  32  operand B to the core.
- gcd_rst  out  1  one-cycle core reset request, ORed with rst at the core.
- gcd_done  in  1  core done pulse.
- gcd_out  in  32  core result register; valid the cycle after gcd_done.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts.
- res_gcd  out  32  result.
- res_a  out  32  echo of operand A.
- res_b  out  32  echo of operand B.
- res_err  out  1  1 means (0,0) input or timeout.

Behaviour:
- Reset: in_ready=1, FIFO empty, state IDLE. gcd_go, gcd_rst, res_valid and res_err are 0. gcd_in1, gcd_in2, res_gcd, res_a, res_b are 0. Watchdog is 0.
- FIFO: push on in_valid&&in_ready. Push while full is impossible because in_ready=0. Push and pop in the same cycle are both allowed, including when full; count is unchanged. Pointers wrap mod DEPTH.
- IDLE, FIFO not empty: pop the head into op_a/op_b.
  - Both operands nonzero: drive gcd_in1/gcd_in2 from op_a/op_b, go to ISSUE.
  - Exactly one operand zero: res_gcd = the other operand, res_err=0, go to HOLD. No core job.
  - Both zero: res_gcd=0, res_err=1, go to HOLD.
- ISSUE: gcd_go=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT: gcd_in1/gcd_in2 stay stable, as they do through the whole job. The watchdog increments each cycle.
  - gcd_done=1: go to CAPTURE.
  - Watchdog reaches TIMEOUT-1 with no done: gcd_rst=1 for one cycle, res_gcd=0, res_err=1, go to HOLD.
- CAPTURE: one cycle. Latch gcd_out into res_gcd, set res_err=0, go to HOLD.
- HOLD: res_valid=1. res_gcd, res_a, res_b and res_err stay stable until res_ready. Then: res_valid=0 on the next edge, and go to IDLE.
- Throughput: the next FIFO pop happens no earlier than the IDLE cycle after the handshake. gcd_go is never asserted while a job is outstanding.
- Unexpected gcd_done: ignored outside WAIT.
- Reset mid-job: the state machine returns to IDLE, the FIFO is flushed, and the result is dropped. gcd_rst is not pulsed because the core sees rst directly.
- gcd_done arriving in the same cycle the watchdog expires: done wins, go to CAPTURE.

Decomposition:
- Shared package gcd_pkg:
  - Data width constant GCD_W=32.
  - State encoding for IDLE, ISSUE, WAIT, CAPTURE, HOLD.
  - Default TIMEOUT.
- One sub-module: sync_fifo, holding {a,b} 64 bits wide, with parameter DEPTH, push/pop, full/empty, and a synchronous active-high rst.

Test Plan:
1. Push (48,18) with res_ready=1 and the real GCD core attached -> exactly one gcd_go pulse, then res_valid with res_gcd=6, res_a=48, res_b=18, res_err=0.
2. Push (0,9), then (12,0) -> res_gcd=9, then 12, both with res_err=0. No gcd_go pulse seen.
3. Push (0,0) -> res_gcd=0, res_err=1, no gcd_go pulse.
4. Push 5 pairs back-to-back with DEPTH=4 while res_ready=0 -> in_ready drops once the FIFO is full.
   - After res_ready=1: results come out in order, (7,7)->7, (21,14)->7, (100,75)->25, (17,5)->1, (64,48)->16.
   - res outputs stay stable while stalled.
5. TIMEOUT=8 with a core model that never asserts done, push (3,5) -> gcd_rst pulses for one cycle 8 cycles after gcd_go. Result: res_gcd=0, res_err=1.
   - The next job (9,6) then completes with 3.
6. Assert rst during WAIT of job (48,18) -> the FIFO empties, res_valid=0, and no result is produced for that job.
   - A new push of (48,18) after reset yields 6.
